// File: rtl/alu_writeback_stage.sv
// Purpose: ALU writeback stage; aligns issue-time control with the registered ALU result and commits Acc/PC/flags.
// Latency: issue in cycle N, commit on the edge ending N+1; WBValid/BranchTaken pulse in N+2.
// Backpressure: Stall parks a pending result in a one-entry hold buffer; InReady drops while stalled or holding.
//
// Ports:
//   CLK, Reset (sync, active-high)     clock and reset
//   InValid/InReady                    issue handshake
//   AccWrite, IsBranch, BranchTarget   issue-time control, carried one cycle
//   ALUOut, ShouldBranch               registered ALU outputs, valid cycle after issue
//   Stall, Flush                       block commit / discard in-flight ops
//   Acc, PC, ZeroFlag, NegFlag         architectural state
//   WBValid, BranchTaken               commit pulses
// Optional feature: define WB_LINK_EN to add IsLink (taken link branch writes old PC+1 into Acc).
module alu_writeback_stage #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic             AccWrite,
  input  logic             IsBranch,
  input  logic [WIDTH-1:0] BranchTarget,
`ifdef WB_LINK_EN
  input  logic             IsLink,
`endif
  input  logic [WIDTH-1:0] ALUOut,
  input  logic             ShouldBranch,
  input  logic             Stall,
  input  logic             Flush,
  output logic [WIDTH-1:0] Acc,
  output logic [WIDTH-1:0] PC,
  output logic             ZeroFlag,
  output logic             NegFlag,
  output logic             WBValid,
  output logic             BranchTaken
);

  // Stage-1: control captured at issue, waiting for the ALU result.
  logic             s1_vld_q, s1_vld_d;
  logic             s1_accw_q, s1_accw_d;
  logic             s1_br_q, s1_br_d;
  logic [WIDTH-1:0] s1_tgt_q, s1_tgt_d;
  logic             s1_link_q, s1_link_d;

  // Hold buffer: result plus control parked across a stall.
  logic             hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] hold_res_q, hold_res_d;
  logic             hold_sb_q, hold_sb_d;
  logic             hold_accw_q, hold_accw_d;
  logic             hold_br_q, hold_br_d;
  logic [WIDTH-1:0] hold_tgt_q, hold_tgt_d;
  logic             hold_link_q, hold_link_d;

  // Architectural state and commit pulses.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             wbv_q, wbv_d;
  logic             bt_q, bt_d;

  logic             link_i;
  logic             issue, commit, taken, wb_en;
  logic             c_accw, c_br, c_sb, c_link;
  logic [WIDTH-1:0] c_res, c_tgt, pc_inc, wb_dat;

`ifdef WB_LINK_EN
  assign link_i = IsLink;
`else
  assign link_i = 1'b0;
`endif

  assign InReady = ~Stall & ~hold_vld_q & ~Reset;

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_accw_d   = s1_accw_q;
    s1_br_d     = s1_br_q;
    s1_tgt_d    = s1_tgt_q;
    s1_link_d   = s1_link_q;
    hold_vld_d  = hold_vld_q;
    hold_res_d  = hold_res_q;
    hold_sb_d   = hold_sb_q;
    hold_accw_d = hold_accw_q;
    hold_br_d   = hold_br_q;
    hold_tgt_d  = hold_tgt_q;
    hold_link_d = hold_link_q;
    acc_d       = acc_q;
    pc_d        = pc_q;
    z_d         = z_q;
    n_d         = n_q;

    issue = InValid & InReady;

    // Stage-1 and hold are never both valid: issue is blocked while holding,
    // and a stalled result moves stage-1 into hold. The hold entry takes precedence.
    commit = ~Flush & ~Stall & (hold_vld_q | s1_vld_q);
    c_res  = hold_vld_q ? hold_res_q  : ALUOut;
    c_sb   = hold_vld_q ? hold_sb_q   : ShouldBranch;
    c_accw = hold_vld_q ? hold_accw_q : s1_accw_q;
    c_br   = hold_vld_q ? hold_br_q   : s1_br_q;
    c_tgt  = hold_vld_q ? hold_tgt_q  : s1_tgt_q;
    c_link = hold_vld_q ? hold_link_q : s1_link_q;

    taken  = c_br & c_sb;
    pc_inc = pc_q + WIDTH'(1);

    wb_en  = c_accw;
    wb_dat = c_res;
    // A taken link branch writes the return address instead of the ALU result.
    if (taken && c_link) begin
      wb_en  = 1'b1;
      wb_dat = pc_inc;
    end

    // Every stage-1 entry is consumed the cycle after issue (commit or hold),
    // so stage-1 validity is simply "issued last cycle".
    s1_vld_d = issue & ~Flush;
    if (issue) begin
      s1_accw_d = AccWrite;
      s1_br_d   = IsBranch;
      s1_tgt_d  = BranchTarget;
      s1_link_d = link_i;
    end

    if (Flush) begin
      hold_vld_d = 1'b0;
    end else if (hold_vld_q) begin
      hold_vld_d = Stall;
    end else if (s1_vld_q && Stall) begin
      hold_vld_d  = 1'b1;
      hold_res_d  = ALUOut;
      hold_sb_d   = ShouldBranch;
      hold_accw_d = s1_accw_q;
      hold_br_d   = s1_br_q;
      hold_tgt_d  = s1_tgt_q;
      hold_link_d = s1_link_q;
    end

    if (commit) begin
      pc_d = taken ? c_tgt : pc_inc;
      if (wb_en) begin
        acc_d = wb_dat;
        z_d   = (wb_dat == '0);
        n_d   = wb_dat[WIDTH-1];
      end
    end

    wbv_d = commit;
    bt_d  = commit & taken;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_vld_q    <= 1'b0;
      s1_accw_q   <= 1'b0;
      s1_br_q     <= 1'b0;
      s1_tgt_q    <= '0;
      s1_link_q   <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_res_q  <= '0;
      hold_sb_q   <= 1'b0;
      hold_accw_q <= 1'b0;
      hold_br_q   <= 1'b0;
      hold_tgt_q  <= '0;
      hold_link_q <= 1'b0;
      acc_q       <= '0;
      pc_q        <= RESET_PC;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      wbv_q       <= 1'b0;
      bt_q        <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_accw_q   <= s1_accw_d;
      s1_br_q     <= s1_br_d;
      s1_tgt_q    <= s1_tgt_d;
      s1_link_q   <= s1_link_d;
      hold_vld_q  <= hold_vld_d;
      hold_res_q  <= hold_res_d;
      hold_sb_q   <= hold_sb_d;
      hold_accw_q <= hold_accw_d;
      hold_br_q   <= hold_br_d;
      hold_tgt_q  <= hold_tgt_d;
      hold_link_q <= hold_link_d;
      acc_q       <= acc_d;
      pc_q        <= pc_d;
      z_q         <= z_d;
      n_q         <= n_d;
      wbv_q       <= wbv_d;
      bt_q        <= bt_d;
    end
  end

  assign Acc         = acc_q;
  assign PC          = pc_q;
  assign ZeroFlag    = z_q;
  assign NegFlag     = n_q;
  assign WBValid     = wbv_q;
  assign BranchTaken = bt_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Purpose: directed, table-driven check of alu_writeback_stage (commit, branch, stall/hold, flush, wrap, reset).
// Latency: each table row is one clock; expectations are the outputs seen during that row.
// Backpressure: Stall/Flush rows exercise hold, InReady drop and discard behaviour.
module tb_alu_writeback_stage;

  logic        CLK = 1'b0;
  logic        Reset, InValid, InReady, AccWrite, IsBranch, ShouldBranch, Stall, Flush;
  logic        IsLink;
  logic [15:0] BranchTarget, ALUOut, Acc, PC;
  logic        ZeroFlag, NegFlag, WBValid, BranchTaken;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  alu_writeback_stage dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .AccWrite(AccWrite), .IsBranch(IsBranch), .BranchTarget(BranchTarget),
`ifdef WB_LINK_EN
    .IsLink(IsLink),
`endif
    .ALUOut(ALUOut), .ShouldBranch(ShouldBranch), .Stall(Stall), .Flush(Flush),
    .Acc(Acc), .PC(PC), .ZeroFlag(ZeroFlag), .NegFlag(NegFlag),
    .WBValid(WBValid), .BranchTaken(BranchTaken)
  );

  typedef struct {
    logic        inv, accw, isbr;
    logic [15:0] tgt, alu;
    logic        sb, stall, flush;
    logic [15:0] e_acc, e_pc;
    logic        e_z, e_n, e_wbv, e_bt, e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic inv, accw, isbr, input logic [15:0] tgt, alu,
                              input logic sb, stall, flush, input logic [15:0] acc, pc,
                              input logic z, n, wbv, bt, rdy);
    vec_t v;
    v.inv = inv; v.accw = accw; v.isbr = isbr; v.tgt = tgt; v.alu = alu;
    v.sb = sb; v.stall = stall; v.flush = flush;
    v.e_acc = acc; v.e_pc = pc; v.e_z = z; v.e_n = n; v.e_wbv = wbv; v.e_bt = bt; v.e_rdy = rdy;
    return v;
  endfunction

  task automatic chk16(input string nm, input int row, input logic [15:0] act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
  endtask

  task automatic chk1(input string nm, input int row, input logic act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %b expected %b", nm, row, act, exp);
  endtask

  task automatic drive(input logic inv, accw, isbr, link, input logic [15:0] tgt, alu,
                       input logic sb, stall, flush);
    InValid = inv; AccWrite = accw; IsBranch = isbr; IsLink = link; BranchTarget = tgt;
    ALUOut = alu; ShouldBranch = sb; Stall = stall; Flush = flush;
  endtask

  task automatic check_state(input int row, input logic [15:0] acc, pc,
                             input logic z, n, wbv, bt, rdy);
    chk16("Acc", row, Acc, acc);
    chk16("PC", row, PC, pc);
    chk1("ZeroFlag", row, ZeroFlag, z);
    chk1("NegFlag", row, NegFlag, n);
    chk1("WBValid", row, WBValid, wbv);
    chk1("BranchTaken", row, BranchTaken, bt);
    chk1("InReady", row, InReady, rdy);
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);

    //     inv accw isbr tgt       alu      sb st fl | acc      pc       z n wbv bt rdy
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1)); // 0 idle
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1)); // 1 idle
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1)); // 2 idle
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1)); // 3 issue accw
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1)); // 4 result 2
    tbl.push_back(mk(1, 0, 1, 16'h0040, 16'h0000, 0, 0, 0, 16'h0002, 16'h0001, 0, 0, 1, 0, 1)); // 5 issue br 40
    tbl.push_back(mk(1, 0, 1, 16'h0080, 16'h1234, 1, 0, 0, 16'h0002, 16'h0001, 0, 0, 0, 0, 1)); // 6 taken + issue br 80
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h5555, 0, 0, 0, 16'h0002, 16'h0040, 0, 0, 1, 1, 1)); // 7 not taken + issue
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0002, 16'h0041, 0, 0, 1, 0, 1)); // 8 result 0
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0042, 1, 0, 1, 0, 1)); // 9 issue accw
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h8000, 0, 1, 0, 16'h0000, 16'h0042, 1, 0, 0, 0, 0)); // 10 stall, capture
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h1234, 0, 1, 0, 16'h0000, 16'h0042, 1, 0, 0, 0, 0)); // 11 stall, issue ignored
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h1234, 0, 1, 0, 16'h0000, 16'h0042, 1, 0, 0, 0, 0)); // 12 stall
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h1234, 0, 0, 0, 16'h0000, 16'h0042, 1, 0, 0, 0, 0)); // 13 release, holding
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h7777, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 1, 0, 1)); // 14 committed 8000
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 15 single pulse
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 16 issue
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 17 flush beats commit
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 18 no commit
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 19 issue+flush
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 20
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 21 still nothing
    tbl.push_back(mk(1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 22 issue
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0005, 0, 1, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 0)); // 23 stall, capture
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0005, 0, 1, 1, 16'h8000, 16'h0043, 0, 1, 0, 0, 0)); // 24 flush hold
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 25 hold gone
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 26 no commit
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 16'h0000, 0, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 27 issue br FFFF
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h8000, 16'h0043, 0, 1, 0, 0, 1)); // 28 taken
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'hFFFF, 0, 1, 1, 1, 1)); // 29 issue plain op
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h1111, 0, 0, 0, 16'h8000, 16'hFFFF, 0, 1, 0, 0, 1)); // 30 commit, wrap
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0000, 0, 1, 1, 0, 1)); // 31 PC wrapped
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h8000, 16'h0000, 0, 1, 0, 0, 1)); // 32 idle

    @(negedge CLK);
    #1 chk1("InReady_in_reset", -1, InReady, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge CLK);
      drive(tbl[i].inv, tbl[i].accw, tbl[i].isbr, 1'b0, tbl[i].tgt, tbl[i].alu,
            tbl[i].sb, tbl[i].stall, tbl[i].flush);
      #1;
      check_state(i, tbl[i].e_acc, tbl[i].e_pc, tbl[i].e_z, tbl[i].e_n,
                  tbl[i].e_wbv, tbl[i].e_bt, tbl[i].e_rdy);
    end

    // Reset while an op is in flight: nothing commits, state returns to reset values.
    @(negedge CLK);
    drive(1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    @(negedge CLK);
    Reset = 1'b1;
    drive(0, 0, 0, 0, 16'h0, 16'h0003, 0, 0, 0);
    #1 chk1("InReady_mid_reset", 100, InReady, 1'b0);
    @(negedge CLK);
    Reset = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 16'h0003, 0, 0, 0);
    #1 check_state(101, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
    @(negedge CLK);
    #1 check_state(102, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);

`ifdef WB_LINK_EN
    // Taken link branch from PC 0x0010 returns 0x0011 in Acc, overriding AccWrite data.
    @(negedge CLK);
    drive(1, 0, 1, 0, 16'h0010, 16'h0, 0, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    @(negedge CLK);
    drive(1, 1, 1, 1, 16'h0100, 16'h0, 0, 0, 0);
    #1 chk16("PC_before_link", 200, PC, 16'h0010);
    @(negedge CLK);
    drive(0, 0, 0, 0, 16'h0, 16'h9999, 1, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    #1 check_state(201, 16'h0011, 16'h0100, 0, 0, 1, 1, 1);
`endif

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
